led_multi_ctrl: RTL and testbench

- Parametrised successor to the single-LED threshold indicator.
- Drives NUM_LEDS LED outputs, each fired by comparing the shared memory-location counter i_mem_link against a per-channel threshold.
- Each channel has a runtime-programmable mode (OFF, LATCH, LEVEL, BLINK) and can be cleared and re-armed.
- Sits between the data-memory probe and the board LED pins.

---
 rtl/led_multi_ctrl_pkg.sv | 24 ++
 rtl/led_multi_ctrl_if.sv | 24 ++
 rtl/led_multi_ctrl_channel.sv | 95 +++++++++
 rtl/led_multi_ctrl.sv | 52 +++++
 tb/tb_led_multi_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_multi_ctrl_pkg.sv
// Shared encodings and helpers for the multi-channel LED threshold indicator.
package led_pkg;

    localparam int LED_CLK_HZ = 27_000_000;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_LATCH = 2'd1,
        LED_LEVEL = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_FIRED    = 2'd1,
        ST_DISARMED = 2'd2
    } led_state_e;

    // Bit width needed to index n items, never less than one bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_multi_ctrl_if.sv
// Probe/config/LED bundle between the memory probe, the config master and the LED controller.
interface led_multi_ctrl_if #(
    parameter int NUM_LEDS = 4,
    parameter int DATA_W   = 32
);
    logic [DATA_W-1:0]                         i_mem_link;
    logic                                      i_cfg_we;
    logic [led_pkg::width_min1(NUM_LEDS)-1:0]  i_cfg_idx;
    logic [1:0]                                i_cfg_mode;
    logic [DATA_W-1:0]                         i_cfg_thresh;
    logic                                      i_clear;
    logic [NUM_LEDS-1:0]                       o_led_signal;
    logic [NUM_LEDS-1:0]                       o_fired;

    modport master (
        output i_mem_link, i_cfg_we, i_cfg_idx, i_cfg_mode, i_cfg_thresh, i_clear,
        input  o_led_signal, o_fired
    );

    modport slave (
        input  i_mem_link, i_cfg_we, i_cfg_idx, i_cfg_mode, i_cfg_thresh, i_clear,
        output o_led_signal, o_fired
    );
endinterface

// File: rtl/led_multi_ctrl_channel.sv
// One LED channel: mode/threshold registers, ARMED/FIRED/DISARMED FSM, blink counter
// and the registered LED drive.
module led_channel
    import led_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                BLINK_HALF = 13_500_000,
    parameter logic [DATA_W-1:0] RST_THRESH = '0,
    parameter logic [1:0]        RST_MODE   = 2'd0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_mem_link,
    input  logic              i_cfg_we,
    input  logic [1:0]        i_cfg_mode,
    input  logic [DATA_W-1:0] i_cfg_thresh,
    input  logic              i_clear,
    output logic              o_led,
    output logic              o_fired
);
    localparam int               CNT_W    = width_min1(BLINK_HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    led_mode_e         mode_q,   mode_d;
    logic [DATA_W-1:0] thresh_q, thresh_d;
    led_state_e        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              led_q,    led_d;
    logic              hit;

    assign hit = (i_mem_link >= thresh_q);

    always_comb begin
        mode_d   = mode_q;
        thresh_d = thresh_q;
        state_d  = state_q;
        cnt_d    = '0;
        led_d    = 1'b0;
        // A config write re-arms the channel and overrides both hit and clear.
        if (i_cfg_we) begin
            mode_d   = led_mode_e'(i_cfg_mode);
            thresh_d = i_cfg_thresh;
            state_d  = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (hit && (mode_q == LED_LATCH || mode_q == LED_BLINK))
                        state_d = i_clear ? ST_DISARMED : ST_FIRED;
                end
                ST_FIRED:    if (i_clear) state_d = ST_DISARMED;
                ST_DISARMED: if (!hit)    state_d = ST_ARMED;
                default:     state_d = ST_ARMED;
            endcase

            case (mode_q)
                LED_OFF:   led_d = 1'b0;
                LED_LATCH: led_d = (state_d == ST_FIRED);
                LED_LEVEL: led_d = hit;
                LED_BLINK: begin
                    if (state_d == ST_FIRED) begin
                        if (state_q != ST_FIRED) begin
                            led_d = 1'b1;
                        end else if (cnt_q == CNT_LAST) begin
                            led_d = ~led_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            led_d = led_q;
                        end
                    end
                end
                default: led_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q   <= led_mode_e'(RST_MODE);
            thresh_q <= RST_THRESH;
            state_q  <= ST_ARMED;
            cnt_q    <= '0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            thresh_q <= thresh_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
        end
    end

    assign o_led   = led_q;
    assign o_fired = (state_q == ST_FIRED);

endmodule

// File: rtl/led_multi_ctrl.sv
// Multi-channel LED threshold indicator: decodes config writes and fans the probe
// value and clear out to one led_channel per LED.
module led_multi_ctrl
    import led_pkg::*;
#(
    parameter int                NUM_LEDS    = 4,
    parameter int                DATA_W      = 32,
    parameter int                BLINK_HALF  = 13_500_000,
    parameter logic [DATA_W-1:0] RST_THRESH0 = DATA_W'(16_875_000),
    parameter logic [1:0]        RST_MODE0   = 2'd1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    led_multi_ctrl_if.slave   bus
);
    localparam int IDX_W = width_min1(NUM_LEDS);

    logic [NUM_LEDS-1:0] led_w;
    logic [NUM_LEDS-1:0] fired_w;

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            localparam logic [DATA_W-1:0] TH_RST   = (gi == 0) ? RST_THRESH0 : '0;
            localparam logic [1:0]        MODE_RST = (gi == 0) ? RST_MODE0   : 2'd0;

            // Out-of-range indices match no channel and are dropped here.
            logic we_sel;
            assign we_sel = bus.i_cfg_we && (bus.i_cfg_idx == IDX_W'(gi));

            led_channel #(
                .DATA_W     (DATA_W),
                .BLINK_HALF (BLINK_HALF),
                .RST_THRESH (TH_RST),
                .RST_MODE   (MODE_RST)
            ) u_ch (
                .i_clk        (i_clk),
                .i_rst_n      (i_rst_n),
                .i_mem_link   (bus.i_mem_link),
                .i_cfg_we     (we_sel),
                .i_cfg_mode   (bus.i_cfg_mode),
                .i_cfg_thresh (bus.i_cfg_thresh),
                .i_clear      (bus.i_clear),
                .o_led        (led_w[gi]),
                .o_fired      (fired_w[gi])
            );
        end
    endgenerate

    assign bus.o_led_signal = led_w;
    assign bus.o_fired      = fired_w;

endmodule

// File: tb/tb_led_multi_ctrl.sv
// Scoreboard bench for led_multi_ctrl: directed scenarios plus random traffic checked
// against a cycle-age behavioural model.
module tb_led_multi_ctrl;
    localparam int          N    = 4;
    localparam int          DW   = 32;
    localparam int          HALF = 4;
    localparam logic [31:0] T0   = 32'd16_875_000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_multi_ctrl_if #(.NUM_LEDS(N), .DATA_W(DW)) bus();

    led_multi_ctrl #(
        .NUM_LEDS   (N),
        .DATA_W     (DW),
        .BLINK_HALF (HALF)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] led;
        logic [N-1:0] fired;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model: mode numbers, thresholds, fired/disarmed flags, cycles since firing.
    int          m_mode [N];
    logic [31:0] m_thr  [N];
    bit          m_fired[N];
    bit          m_dis  [N];
    int          m_age  [N];
    bit          m_led  [N];

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_mode[k]  = (k == 0) ? 1 : 0;
            m_thr[k]   = (k == 0) ? T0 : 32'd0;
            m_fired[k] = 0;
            m_dis[k]   = 0;
            m_age[k]   = 0;
            m_led[k]   = 0;
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want, input int c);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cyc%0d %s: got %b expected %b", c, name, got, want);
        end
    endtask

    // Apply one cycle of inputs, predict the post-edge outputs, advance to the next slot.
    task automatic step(input bit we, input int idx, input int md, input logic [31:0] th,
                        input bit clr, input logic [31:0] link);
        exp_t e;
        bit   hit, was;
        bus.i_cfg_we     = we;
        bus.i_cfg_idx    = 2'(idx);
        bus.i_cfg_mode   = 2'(md);
        bus.i_cfg_thresh = th;
        bus.i_clear      = clr;
        bus.i_mem_link   = link;
        for (int k = 0; k < N; k++) begin
            hit = (link >= m_thr[k]);
            if (we && idx == k) begin
                m_mode[k] = md; m_thr[k] = th;
                m_fired[k] = 0; m_dis[k] = 0; m_age[k] = 0; m_led[k] = 0;
            end else begin
                was = m_fired[k];
                if (m_mode[k] == 1 || m_mode[k] == 3) begin
                    if (m_fired[k]) begin
                        if (clr) begin m_fired[k] = 0; m_dis[k] = 1; end
                    end else if (m_dis[k]) begin
                        if (!hit) m_dis[k] = 0;
                    end else if (hit) begin
                        if (clr) m_dis[k] = 1; else m_fired[k] = 1;
                    end
                end
                case (m_mode[k])
                    0: m_led[k] = 0;
                    1: m_led[k] = m_fired[k];
                    2: m_led[k] = hit;
                    default: begin
                        if (m_fired[k]) begin
                            m_age[k] = was ? m_age[k] + 1 : 0;
                            m_led[k] = ((m_age[k] / HALF) % 2) == 0;
                        end else begin
                            m_age[k] = 0;
                            m_led[k] = 0;
                        end
                    end
                endcase
            end
            e.led[k]   = m_led[k];
            e.fired[k] = m_fired[k];
        end
        cyc++;
        e.cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are valid every cycle; compare whenever a prediction is pending.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("led_signal", bus.o_led_signal, e.led, e.cyc);
            check("fired", bus.o_fired, e.fired, e.cyc);
            $display("cyc%0d link=%0d led=%b fired=%b", e.cyc, bus.i_mem_link, bus.o_led_signal, bus.o_fired);
        end
    end

    initial begin
        logic [31:0] cur_link;
        bus.i_cfg_we = 0; bus.i_cfg_idx = '0; bus.i_cfg_mode = '0;
        bus.i_cfg_thresh = '0; bus.i_clear = 0; bus.i_mem_link = '0;
        model_reset();
        @(posedge clk);
        #2;
        check("reset_led", bus.o_led_signal, '0, 0);
        check("reset_fired", bus.o_fired, '0, 0);
        rst_n = 1'b1;

        // Default channel 0 latches one cycle after the link reaches its threshold.
        step(0, 0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 0, T0 - 2);
        step(0, 0, 0, 0, 0, T0 - 1);
        step(0, 0, 0, 0, 0, T0);
        step(0, 0, 0, 0, 0, T0 + 1);

        // Channel 1 LEVEL around threshold 100.
        step(1, 1, 2, 32'd100, 0, 32'd99);
        step(0, 0, 0, 0, 0, 32'd99);
        step(0, 0, 0, 0, 0, 32'd100);
        step(0, 0, 0, 0, 0, 32'd99);
        step(0, 0, 0, 0, 0, 32'd99);

        // Channel 2 BLINK at threshold 10, link held.
        step(1, 2, 3, 32'd10, 0, 32'd10);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 32'd10);

        // Clear channel 0 while still hit, then drop and re-raise the link.
        step(0, 0, 0, 0, 0, T0 + 5);
        step(0, 0, 0, 0, 1, T0 + 5);
        step(0, 0, 0, 0, 0, T0 + 5);
        step(0, 0, 0, 0, 0, T0 + 5);
        step(0, 0, 0, 0, 0, 32'd3);
        step(0, 0, 0, 0, 0, T0);
        step(0, 0, 0, 0, 0, T0);

        // Channel 3: write racing a hit, then fire on the new threshold.
        step(1, 3, 1, 32'd50, 0, 32'd0);
        step(1, 3, 1, 32'd8, 0, 32'd60);
        step(0, 0, 0, 0, 0, 32'd60);
        step(0, 0, 0, 0, 0, 32'd60);

        // Clear racing an ARMED->FIRED transition on channel 3.
        step(1, 3, 1, 32'd70, 0, 32'd0);
        step(0, 0, 0, 0, 1, 32'd80);
        step(0, 0, 0, 0, 0, 32'd80);

        // Clear racing a config write: channel 0 re-armed by the write, others cleared.
        step(0, 0, 0, 0, 0, T0);
        step(1, 0, 1, T0, 1, T0);
        step(0, 0, 0, 0, 0, T0);

        // Async reset mid-blink, between clock edges.
        step(1, 2, 3, 32'd10, 0, 32'd10);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 32'd10);
        sb.delete();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", bus.o_led_signal, '0, cyc);
        check("async_rst_fired", bus.o_fired, '0, cyc);
        model_reset();
        @(posedge clk);
        #2;
        check("held_rst_led", bus.o_led_signal, '0, cyc);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, T0 - 1);
        step(0, 0, 0, 0, 0, T0);
        step(0, 0, 0, 0, 0, T0);

        // Random traffic with small thresholds so hits and clears interact.
        cur_link = 32'd0;
        for (int i = 0; i < 600; i++) begin
            bit          we, clr;
            int          idx, md;
            logic [31:0] th;
            we  = ($urandom_range(0, 7) == 0);
            idx = $urandom_range(0, N - 1);
            md  = $urandom_range(0, 3);
            th  = 32'($urandom_range(0, 63));
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                cur_link = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
            step(we, idx, md, th, clr, cur_link);
        end

        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
